// File: rtl/accum_alu_seq_pkg.sv
// Shared types for the accumulator ALU: operation codes and control FSM states.
package accum_alu_seq_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpAddc = 4'd1,
    OpSub  = 4'd2,
    OpAnd  = 4'd3,
    OpOr   = 4'd4,
    OpXor  = 4'd5,
    OpXorr = 4'd6,
    OpSlt  = 4'd7,
    OpSeq  = 4'd8,
    OpLsl  = 4'd9,
    OpLsr  = 4'd10,
    OpMul  = 4'd11,
    OpMvto = 4'd12,
    OpNot  = 4'd13,
    OpClr  = 4'd14,
    OpBtru = 4'd15
  } op_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StMul   = 2'd2
  } state_t;

endpackage

// File: rtl/accum_alu_seq_if.sv
// Request/response bundle between the operand-mux stage and the accumulator ALU.
interface accum_alu_seq_if
  import accum_alu_seq_pkg::*;
#(
  parameter int unsigned W = 8
);
  logic         start;
  op_t          op;
  logic [W-1:0] operand_in;
  logic [W-1:0] acc;
  logic         zero;
  logic         carry;
  logic         busy;
  logic         done;
  logic         branch;

  modport master (
    output start, op, operand_in,
    input  acc, zero, carry, busy, done, branch
  );

  modport slave (
    input  start, op, operand_in,
    output acc, zero, carry, busy, done, branch
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one multiplier bit per step, W steps after load.
module alu_mul_seq #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] prod
);
  localparam int unsigned CW = $clog2(W);

  logic [2*W-1:0] prod_q, mcand_q;
  logic [W-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;

  // Product after the current step; valid as the final result when done is high.
  assign prod = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign done = (cnt_q == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      prod_q   <= '0;
      mcand_q  <= {{W{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= '0;
    end else if (step) begin
      prod_q   <= prod;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/accum_alu_seq.sv
// Registered accumulator ALU with Zero/Carry flags; shifts and multiply run iteratively.
module accum_alu_seq
  import accum_alu_seq_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input logic            clk,
  input logic            reset,
  accum_alu_seq_if.slave bus
);
  localparam int unsigned SHW = $clog2(W);

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic           zero_q, zero_d;
  logic           carry_q, carry_d;
  logic           done_q, done_d;
  logic           branch_q, branch_d;
  logic           shl_q, shl_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [W-1:0]   shv_q, shv_d;

  logic           mul_load, mul_step, mul_done;
  logic [2*W-1:0] mul_prod;
  logic [W:0]     sum;
  logic [W-1:0]   shv_next;
  logic           shv_out;
  logic [W-1:0]   opd;
  logic [SHW-1:0] amt;

  assign opd = bus.operand_in;
  assign amt = bus.operand_in[SHW-1:0];

  alu_mul_seq #(
    .W(W)
  ) u_mul (
    .clk  (clk),
    .reset(reset),
    .load (mul_load),
    .step (mul_step),
    .a    (acc_q),
    .b    (opd),
    .done (mul_done),
    .prod (mul_prod)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    branch_d = 1'b0;
    shl_d    = shl_q;
    cnt_d    = cnt_q;
    shv_d    = shv_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    sum      = '0;
    shv_next = shl_q ? {shv_q[W-2:0], 1'b0} : {1'b0, shv_q[W-1:1]};
    shv_out  = shl_q ? shv_q[W-1] : shv_q[0];

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          done_d = 1'b1;
          case (bus.op)
            OpAdd: begin
              sum     = {1'b0, acc_q} + {1'b0, opd};
              acc_d   = sum[W-1:0];
              carry_d = sum[W];
            end
            OpAddc: begin
              sum     = {1'b0, acc_q} + {1'b0, opd} + {{W{1'b0}}, carry_q};
              acc_d   = sum[W-1:0];
              carry_d = sum[W];
            end
            OpSub: begin
              acc_d   = acc_q - opd;
              carry_d = (acc_q < opd);
            end
            OpAnd:  acc_d = acc_q & opd;
            OpOr:   acc_d = acc_q | opd;
            OpXor:  acc_d = acc_q ^ opd;
            OpXorr: acc_d = {{(W-1){1'b0}}, ^opd};
            OpSlt:  acc_d = {{(W-1){1'b0}}, (acc_q < opd)};
            OpSeq:  acc_d = {{(W-1){1'b0}}, (acc_q == opd)};
            OpMvto: acc_d = opd;
            OpNot:  acc_d = ~acc_q;
            OpClr:  acc_d = '0;
            OpLsl, OpLsr: begin
              // Amount 0 completes in this cycle with Acc/Carry untouched.
              if (amt != '0) begin
                state_d = StShift;
                done_d  = 1'b0;
                shl_d   = (bus.op == OpLsl);
                cnt_d   = amt;
                shv_d   = acc_q;
              end
            end
            OpMul: begin
              state_d  = StMul;
              done_d   = 1'b0;
              mul_load = 1'b1;
            end
            OpBtru: branch_d = (acc_q == {{(W-1){1'b0}}, 1'b1});
            default: ;
          endcase
          if (done_d && bus.op != OpBtru) begin
            zero_d = (acc_d == '0);
          end
        end
      end
      StShift: begin
        shv_d = shv_next;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          acc_d   = shv_next;
          carry_d = shv_out;
          zero_d  = (shv_next == '0);
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StMul: begin
        mul_step = 1'b1;
        if (mul_done) begin
          acc_d   = mul_prod[W-1:0];
          carry_d = |mul_prod[2*W-1:W];
          zero_d  = (mul_prod[W-1:0] == '0);
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
      branch_q <= 1'b0;
      shl_q    <= 1'b0;
      cnt_q    <= '0;
      shv_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
      branch_q <= branch_d;
      shl_q    <= shl_d;
      cnt_q    <= cnt_d;
      shv_q    <= shv_d;
    end
  end

  assign bus.acc    = acc_q;
  assign bus.zero   = zero_q;
  assign bus.carry  = carry_q;
  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = done_q;
  assign bus.branch = branch_q;
endmodule

// File: tb/tb_accum_alu_seq.sv
// Bench for accum_alu_seq (W=8): directed vector table, random ops vs. arithmetic model, resets.
module tb_accum_alu_seq;
  import accum_alu_seq_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  accum_alu_seq_if #(.W(8)) bus ();

  accum_alu_seq #(.W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    op_t        op;
    logic [7:0] opd;
    logic [7:0] acc;
    logic       c;
    logic       z;
    logic       br;
    int         lat;
    bit         poke;
  } vec_t;

  vec_t vecs[20];

  // Reference model state.
  logic [7:0] ma;
  logic       mc, mz;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  function automatic void model(input op_t op, input logic [7:0] opd, inout logic [7:0] a,
                                inout logic c, inout logic z, output logic br,
                                output int lat);
    int unsigned t;
    int n;
    n   = int'(opd) % 8;
    br  = 1'b0;
    lat = 0;
    case (op)
      OpAdd:  begin t = int'(a) + int'(opd); a = 8'(t); c = (t > 255); end
      OpAddc: begin t = int'(a) + int'(opd) + int'(c); a = 8'(t); c = (t > 255); end
      OpSub:  begin c = (a < opd); a = 8'(int'(a) - int'(opd)); end
      OpAnd:  a = a & opd;
      OpOr:   a = a | opd;
      OpXor:  a = a ^ opd;
      OpXorr: a = {7'd0, ^opd};
      OpSlt:  a = (a < opd) ? 8'd1 : 8'd0;
      OpSeq:  a = (a == opd) ? 8'd1 : 8'd0;
      OpMvto: a = opd;
      OpNot:  a = ~a;
      OpClr:  a = 8'd0;
      OpLsl: if (n != 0) begin
        t = int'(a) << n; c = t[8]; a = 8'(t); lat = n;
      end
      OpLsr: if (n != 0) begin
        t = int'(a) >> (n - 1); c = t[0]; a = 8'(int'(a) >> n); lat = n;
      end
      OpMul:  begin t = int'(a) * int'(opd); a = 8'(t); c = ((t >> 8) != 0); lat = 8; end
      default: ;
    endcase
    if (op == OpBtru) br = (a == 8'd1);
    else z = (a == 8'd0);
  endfunction

  // Called at a negedge; returns at the negedge on which Done is seen (or the bound expires).
  task automatic exec(input op_t op, input logic [7:0] opd, input bit poke,
                      output logic [7:0] a, output logic c, output logic z, output logic br,
                      output int cyc, output bit hold_ok);
    logic [7:0] pre;
    pre = bus.acc;
    bus.start = 1'b1;
    bus.op = op;
    bus.operand_in = opd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op = op_t'($urandom_range(0, 15));
    bus.operand_in = 8'($urandom);
    @(negedge clk);
    cyc = 0;
    hold_ok = 1'b1;
    while (!bus.done && cyc < 40) begin
      if (!bus.busy || bus.acc !== pre) hold_ok = 1'b0;
      if (poke) begin
        bus.start = 1'b1;
        bus.op = OpClr;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    if (bus.busy) hold_ok = 1'b0;
    a = bus.acc;
    c = bus.carry;
    z = bus.zero;
    br = bus.branch;
  endtask

  task automatic run_checked(input string tag, input int idx, input op_t op,
                             input logic [7:0] opd, input bit poke, input logic [7:0] ea,
                             input logic ec, input logic ez, input logic ebr, input int elat);
    logic [7:0] a;
    logic c, z, br;
    int cyc;
    bit hold_ok;
    exec(op, opd, poke, a, c, z, br, cyc, hold_ok);
    chk({tag, "_acc"}, idx, 32'(a), 32'(ea));
    chk({tag, "_carry"}, idx, 32'(c), 32'(ec));
    chk({tag, "_zero"}, idx, 32'(z), 32'(ez));
    chk({tag, "_branch"}, idx, 32'(br), 32'(ebr));
    chk({tag, "_latency"}, idx, 32'(cyc), 32'(elat));
    chk({tag, "_busy_hold"}, idx, 32'(hold_ok), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic br;
    int lat;
    bit done_seen;

    vecs[0]  = '{OpMvto, 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    vecs[1]  = '{OpAdd,  8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    vecs[2]  = '{OpAddc, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    vecs[3]  = '{OpSub,  8'h12, 8'hFF, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    vecs[4]  = '{OpMvto, 8'h81, 8'h81, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    vecs[5]  = '{OpLsl,  8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 3, 1'b1};
    vecs[6]  = '{OpLsr,  8'h00, 8'h08, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    vecs[7]  = '{OpMvto, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    vecs[8]  = '{OpMul,  8'h11, 8'h10, 1'b1, 1'b0, 1'b0, 8, 1'b1};
    vecs[9]  = '{OpMvto, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    vecs[10] = '{OpBtru, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 0, 1'b0};
    vecs[11] = '{OpMvto, 8'h02, 8'h02, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    vecs[12] = '{OpBtru, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    vecs[13] = '{OpClr,  8'h5A, 8'h00, 1'b1, 1'b1, 1'b0, 0, 1'b0};
    vecs[14] = '{OpSeq,  8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    vecs[15] = '{OpXorr, 8'h07, 8'h01, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    vecs[16] = '{OpSlt,  8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 0, 1'b0};
    vecs[17] = '{OpNot,  8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    vecs[18] = '{OpLsr,  8'h0F, 8'h01, 1'b1, 1'b0, 1'b0, 7, 1'b1};
    vecs[19] = '{OpMul,  8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 8, 1'b1};

    bus.start = 1'b0;
    bus.op = OpAdd;
    bus.operand_in = 8'h00;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_acc", 0, 32'(bus.acc), 32'h0);
    chk("rst_zero", 0, 32'(bus.zero), 32'h0);
    chk("rst_carry", 0, 32'(bus.carry), 32'h0);
    chk("rst_busy", 0, 32'(bus.busy), 32'h0);
    chk("rst_done", 0, 32'(bus.done), 32'h0);
    chk("rst_branch", 0, 32'(bus.branch), 32'h0);
    ma = 8'h00;
    mc = 1'b0;
    mz = 1'b0;

    for (int i = 0; i < 20; i++) begin
      run_checked("vec", i, vecs[i].op, vecs[i].opd, vecs[i].poke, vecs[i].acc, vecs[i].c,
                  vecs[i].z, vecs[i].br, vecs[i].lat);
      model(vecs[i].op, vecs[i].opd, ma, mc, mz, br, lat);
    end

    for (int i = 0; i < 150; i++) begin
      op_t op;
      logic [7:0] opd;
      op = op_t'($urandom_range(0, 15));
      opd = 8'($urandom);
      model(op, opd, ma, mc, mz, br, lat);
      run_checked("rnd", i, op, opd, 1'($urandom_range(0, 1)), ma, mc, mz, br, lat);
    end

    // Reset on the fourth edge of a multiply aborts it without a Done.
    run_checked("pre", 0, OpMvto, 8'h10, 1'b0, 8'h10, mc, 1'b0, 1'b0, 0);
    bus.start = 1'b1;
    bus.op = OpMul;
    bus.operand_in = 8'h11;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_acc", 0, 32'(bus.acc), 32'h0);
    chk("abort_busy", 0, 32'(bus.busy), 32'h0);
    chk("abort_done", 0, 32'(bus.done), 32'h0);
    chk("abort_carry", 0, 32'(bus.carry), 32'h0);
    chk("abort_zero", 0, 32'(bus.zero), 32'h0);
    done_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen = 1'b1;
    end
    chk("abort_quiet", 0, 32'(done_seen), 32'h0);
    run_checked("post", 0, OpAdd, 8'h05, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 0);

    // Reset and Start in the same cycle: Reset wins.
    bus.start = 1'b1;
    bus.op = OpMvto;
    bus.operand_in = 8'hAA;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst_start_acc", 0, 32'(bus.acc), 32'h0);
    chk("rst_start_done", 0, 32'(bus.done), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/accum_alu_seq.md
# accum_alu_seq

Registered, parametrised accumulator ALU for the accumulator-style datapath. It holds the accumulator and the Zero/Carry flags internally, executes one operation per Start/Done handshake, and performs multiply and variable shifts iteratively over several cycles. It sits between the decode/operand-mux stage and register-file writeback. Branch resolution is a registered Done-qualified pulse, not a combinational output.

## Interface
- W, default 8: datapath width, W ≥ 4, power of two.
- SHW, default $clog2(W): shift-amount width, derived, not overridden.
- Clk  in  1  clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  request; accepted only when Busy=0.
- Op  in  4  operation code (alu_pkg::op_t), sampled with Start.
- OperandIn  in  W  second operand (register or immediate, muxed upstream), sampled with Start.
- Acc  out  W  accumulator register.
- Zero  out  1  registered flag.
- Carry  out  1  registered flag.
- Busy  out  1  high while a multi-cycle op runs.
- Done  out  1  one-cycle pulse: result/flags/Branch valid.
- Branch  out  1  valid only with Done; 0 otherwise.

## Operation
- Ops 0–15: ADD, ADDC, SUB, AND, OR, XOR, XORR, SLT, SEQ, LSL, LSR, MUL, MVTO, NOT, CLR, BTRU.
- ADD: Acc+Opd, Carry=carry-out. ADDC: Acc+Opd+Carry, Carry=carry-out. SUB: Acc−Opd mod 2^W, Carry=borrow (1 iff Acc<Opd unsigned).
- AND/OR/XOR/NOT(~Acc): bitwise. XORR: Acc={W-1 zeros, ^Opd}. SLT: Acc=(Acc<Opd) unsigned, zero-extended. SEQ: Acc=(Acc==Opd). MVTO: Acc=Opd. CLR: Acc=0. Carry unchanged for all of these.
- LSL/LSR: amount = Opd[SHW-1:0]; one bit per cycle; zero fill; Carry = last bit shifted out. Amount 0: Acc and Carry unchanged, single-cycle.
- MUL: unsigned Acc×Opd, shift-add, one multiplier bit per cycle for W cycles. Acc = low W bits; Carry = (high W bits ≠ 0).
- BTRU: Branch=1 with Done iff Acc==1; Acc and flags unchanged.
- Zero = (new Acc == 0) on every Acc-writing op (all except BTRU).
- Start with Busy=1 is ignored (no queueing, no error).

## Timing
- Reset values: Acc=0, Zero=0, Carry=0, Busy=0, Done=0, Branch=0, FSM=IDLE.
- FSM states: IDLE, SHIFT, MUL, plus registered Done.
- Single-cycle op (incl. shift amount 0) accepted at edge k: Acc/flags updated at edge k; Done=1 in cycle k..k+1. Back-to-back Start every cycle allowed.
- Shift amount n≥1 accepted at edge k: IDLE→SHIFT, Busy=1 from edge k; Acc updated at edge k+n; Busy=0, Done=1 after edge k+n; SHIFT→IDLE.
- MUL accepted at edge k: IDLE→MUL, Busy=1; final Acc/Carry/Zero written at edge k+W; Done=1 after edge k+W; MUL→IDLE. Acc holds the pre-op value until the final write (partial product kept internally).
- Next Start is accepted on the same edge Busy falls is NOT allowed; first acceptable edge is k+n+1 / k+W+1 (Busy sampled high until then).
- Op/OperandIn are latched at acceptance; later changes have no effect.
- Reset mid-operation: aborts; all outputs return to reset values at that edge; no Done.
- Reset and Start together: Reset wins.

## Structure
- alu_pkg: op_t enum (16 codes above), state_t enum (IDLE, SHIFT, MUL).
- Sub-module alu_mul_seq: W-parameterised shift-add multiplier with load/step/done; top instantiates it and owns the FSM, shifter counter, flags, and Acc.

## Test plan
- W=8, Reset, then observe: Acc=0, flags 0, Busy 0, Done 0.
- MVTO 0xF0, ADD 0x20 → Acc=0x10, Carry=1, Zero=0; ADDC 0x00 → Acc=0x11, Carry=0; SUB 0x12 → Acc=0xFF, Carry=1.
- Acc=0x81, LSL 3 → Busy for 3 cycles, Done after edge k+3, Acc=0x08, Carry=0; LSR 0 → single-cycle, Acc unchanged.
- Acc=0x10, MUL 0x11 → Done after edge k+8, Acc=0x10, Carry=1; Start pulsed during Busy is ignored.
- Acc=0x01, BTRU → Done with Branch=1; Acc=0x02, BTRU → Branch=0; flags unchanged in both.
- Reset asserted mid-MUL (cycle 4) → Acc=0, Busy=0, no Done; next ADD 0x05 → Acc=0x05 one cycle later.
